// File: rtl/signal_spi_pkg.sv
// Shared definitions for the signal-frame SPI transmitter: frame geometry and FSM state type.
package signal_spi_pkg;

  localparam int unsigned SIGNAL_FRAME_BITS = 48;
  localparam int unsigned SIGNAL_BYTES      = 6;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } spi_tx_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer for the SPI transmitter: emits a one-cycle tick every CLK_DIV clk cycles,
// counted from the last cycle in which clear was high.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // A tick also restarts the count, so each phase that begins on a tick starts from zero.
  assign tick = !clear && (cnt_q == CntLast);

  // Divider counter: held at zero by clear, wraps on every tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/signal_spi_tx.sv
// SPI controller-side transmitter for the signal frame (CPOL=0, CPHA=0, MSB first).
// Accepts a frame on valid && ready, then drives cs_n / sck / sdo from clk.
// Optional feature: define SIGNAL_SPI_TX_DEDUP_EN to suppress re-sending a frame identical
// to the last one sent; such a frame only produces a done pulse.
module signal_spi_tx
  import signal_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = SIGNAL_FRAME_BITS,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  valid,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sck,
  output logic                  sdo
);

  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);

  spi_tx_state_t         state_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] shreg_shl;
  logic [BitW-1:0]       bit_cnt_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  cs_n_q;
  logic                  sck_q;
  logic                  sdo_q;

  logic accept;
  logic dup_hit;
  logic tick;
  logic tick_clear;

  assign accept     = valid && (state_q == StIdle);
  assign tick_clear = (state_q == StIdle);
  assign shreg_shl  = shreg_q << 1;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .tick    (tick)
  );

`ifdef SIGNAL_SPI_TX_DEDUP_EN
  logic [FRAME_BITS-1:0] last_frame_q;
  logic                  last_ok_q;

  assign dup_hit = last_ok_q && (frame == last_frame_q);

  // Record each frame as it starts; reset clears last_ok, so an aborted frame never counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_frame_q <= '0;
      last_ok_q    <= 1'b0;
    end else if (accept && !dup_hit) begin
      last_frame_q <= frame;
      last_ok_q    <= 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // Frame sequencer; every output is a register updated on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (dup_hit) begin
              done_q <= 1'b1;
            end else begin
              shreg_q   <= frame;
              bit_cnt_q <= '0;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              cs_n_q    <= 1'b0;
              sdo_q     <= frame[FRAME_BITS-1];
              state_q   <= StSetup;
            end
          end
        end
        StSetup: begin
          if (tick) begin
            sck_q   <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (tick) begin
            if (sck_q) begin
              // Falling edge: present the next bit, receiver has already sampled this one.
              sck_q   <= 1'b0;
              shreg_q <= shreg_shl;
              if (bit_cnt_q == BitLast) begin
                bit_cnt_q <= '0;
                sdo_q     <= 1'b0;
                state_q   <= StHold;
              end else begin
                bit_cnt_q <= bit_cnt_q + BitW'(1);
                sdo_q     <= shreg_shl[FRAME_BITS-1];
              end
            end else begin
              sck_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (tick) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (tick) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign cs_n  = cs_n_q;
  assign sck   = sck_q;
  assign sdo   = sdo_q;

endmodule

// File: doc/signal_spi_tx.md
# signal_spi_tx

SPI controller-side transmitter for the six-byte signal frame (sd0..sd5, 48 bits, sd0 in the MSBs). It is the sending end of the link whose receiver shifts bits in MSB-first on rising `sck` (CPOL=0, CPHA=0). The block accepts a frame over a valid/ready handshake, then generates `cs_n`, `sck` and `sdo` from the system clock. It is used by the loopback and test harness and by any board that drives a tune core from another FPGA.

## Interface
- Parameters:
  - `FRAME_BITS`, default 48: bits per frame; must be ≥ 1.
  - `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; must be ≥ 1.
- Ports (clock and reset first):
  - `clk` in 1: system clock (`int_osc` at top level); all state is on its rising edge.
  - `reset_n` in 1: asynchronous, active-low reset.
  - `frame` in FRAME_BITS: data to send; bit FRAME_BITS-1 goes first.
  - `valid` in 1: `frame` is offered.
  - `ready` out 1: block can accept. A transfer is accepted on a rising edge where `valid && ready`.
  - `busy` out 1: a frame is in progress, from acceptance through the end of GAP.
  - `done` out 1: one-cycle pulse when a frame completes.
  - `cs_n` out 1: chip select, active-low.
  - `sck` out 1: serial clock; idles low.
  - `sdo` out 1: serial data.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. The state enum lives in the package.
- IDLE:
  - `ready`=1, `busy`=0, `cs_n`=1, `sck`=0, `sdo`=0.
  - On accept, latch `frame` into the shift register and go to SETUP.
- SETUP (CLK_DIV cycles):
  - `cs_n`=0, `sdo`=shreg MSB, `sck`=0.
  - Go to SHIFT on the terminal tick.
- SHIFT:
  - `sck` toggles every CLK_DIV cycles.
  - On each falling toggle, shift the register left and fill the LSB with 0. The bit counter then increments.
  - When FRAME_BITS falling edges have completed, go to HOLD. `sck` stays 0.
- HOLD (CLK_DIV cycles):
  - `cs_n`=0, `sdo`=0.
  - On exit: `cs_n`=1, pulse `done`, go to GAP.
- GAP (CLK_DIV cycles):
  - `ready`=0 and `cs_n`=1.
  - Then go to IDLE.
- `ready` is 1 only in IDLE. `valid` in any other state is ignored and does not disturb the frame in flight.
- All outputs are registered: `cs_n`, `sck` and `sdo` never glitch.
- Counter widths:
  - Divider counter: $clog2(CLK_DIV+1) bits.
  - Bit counter: $clog2(FRAME_BITS+1) bits.
  - Neither counter wraps mid-frame; both clear on every state entry.
- Reset mid-frame:
  - Every output goes to its idle value immediately (asynchronous).
  - The FSM returns to IDLE and the partial frame is discarded.
  - The first frame accepted after reset release is transmitted complete.
- Reset values: `ready`=1, `busy`=0, `done`=0, `cs_n`=1, `sck`=0, `sdo`=0.

## Timing
- Let accept occur at edge t0.
  - `cs_n` falls and `sdo`=frame[FRAME_BITS-1] at t0+1.
  - `sck` rise k (k=0..FRAME_BITS-1) occurs at t0+1+CLK_DIV·(1+2k).
  - The matching fall occurs at t0+1+CLK_DIV·(2+2k).
  - `sdo` is stable for CLK_DIV cycles on each side of every rising `sck`.
- `cs_n` is low for CLK_DIV·(2·FRAME_BITS+1) cycles. With the defaults this is 388 cycles.
- `done` and the `cs_n` rise occur in the same cycle. `ready` returns CLK_DIV cycles later.
- The minimum `cs_n` high time between back-to-back frames is CLK_DIV+1 cycles: GAP plus the IDLE accept cycle.

## Configuration
- `SIGNAL_SPI_TX_DEDUP_EN`:
  - Defined: the block keeps a `last_frame` register and a `last_ok` flag (cleared by reset).
    - An accepted frame equal to `last_frame` while `last_ok`=1 causes no bus activity.
    - Instead, `done` pulses at t0+1 and `ready` stays 1.
    - Every frame actually sent updates `last_frame` and sets `last_ok`.
    - A frame aborted by reset is not recorded.
  - Undefined: every accepted frame is transmitted. There is no `last_frame` storage.

## Structure
- Package `signal_spi_pkg` holds:
  - the state typedef `spi_tx_state_t`;
  - `SIGNAL_FRAME_BITS`=48 and `SIGNAL_BYTES`=6.
- Sub-module `spi_tick_gen`:
  - Ports: `clk`, `reset_n`, `clear`, `tick`. Parameter `CLK_DIV`.
  - Emits `tick` every CLK_DIV cycles after `clear`.
  - Drives all SETUP, SHIFT, HOLD and GAP timing.

## Test plan
All scenarios use CLK_DIV=4 and FRAME_BITS=48.
- **Reset:** assert `reset_n`=0 → `cs_n`=1, `sck`=0, `sdo`=0, `ready`=1, `busy`=0, `done`=0.
- **Single frame:** send 48'hA5_3C_0F_F0_81_7E → a bench receiver sampling on rising `sck` captures exactly that value. Also check: 48 rises, `cs_n` low 388 cycles, one `done` pulse coincident with the `cs_n` rise.
- **Valid while busy:** after accepting 48'h1, hold `valid` with 48'h2 → 48'h1 is sent intact. 48'h2 is accepted at the first IDLE cycle, giving `cs_n` high for exactly 5 cycles.
- **Reset mid-frame:** pulse `reset_n` low during bit 20 → outputs reach idle values with no `clk` edge. After release, 48'hFFFF_0000_FFFF is received complete.
- **Boundary patterns:** all-zeros frame → `sdo` stays 0 but `cs_n`, `sck` and `done` behave as for any frame. All-ones frame → `sdo` is 1 from t0+1 through the last fall, then 0 in HOLD.
- **Dedup:** with `SIGNAL_SPI_TX_DEDUP_EN`, send 48'hDEAD_BEEF_0042 twice → one bus frame only; the second `done` arrives 1 cycle after accept. A zero frame right after reset is still transmitted. Without the macro → two full frames.
